// File: rtl/fixture_picobello.sv
// Boot/test sequencer for the Picobello harness: configures the chip, preloads
// binaries over the selected debug interface, polls EOC and reports the exit code.
module fixture_picobello #(
  parameter int unsigned RstCycles    = 16,
  parameter int unsigned PollInterval = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  input  logic        sn_valid_i,
  output logic [1:0]  boot_mode_o,
  output logic        chip_rst_o,
  output logic [1:0]  if_sel_o,
  output logic        init_req_o,
  input  logic        init_ack_i,
  output logic        load_req_o,
  input  logic        load_ack_i,
  output logic        run_req_o,
  input  logic        run_ack_i,
  output logic        read_req_o,
  input  logic        read_ack_i,
  output logic        poll_req_o,
  input  logic        poll_ack_i,
  input  logic [31:0] poll_data_i,
  input  logic        uart_busy_i,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] exit_code_o
);

  localparam int unsigned MaxCnt = (RstCycles > PollInterval) ? RstCycles : PollInterval;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  localparam logic [1:0] IfJtag  = 2'd0;
  localparam logic [1:0] IfSlink = 2'd1;
  localparam logic [1:0] IfUart  = 2'd2;
  localparam logic [1:0] IfFast  = 2'd3;

  localparam logic [1:0] ErrBoot    = 2'd1;
  localparam logic [1:0] ErrPreload = 2'd2;

  typedef enum logic [3:0] {
    StIdle, StReset, StDispatch, StInit, StLoad, StRun,
    StPoll, StPollWait, StRead, StDrain, StDone, StError
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        boot_q, boot_d;
  logic [1:0]        preload_q, preload_d;
  logic              sn_valid_q, sn_valid_d;
  logic              chip_rst_q, chip_rst_d;
  logic [1:0]        if_sel_q, if_sel_d;
  logic              init_req_q, init_req_d;
  logic              load_req_q, load_req_d;
  logic              run_req_q, run_req_d;
  logic              read_req_q, read_req_d;
  logic              poll_req_q, poll_req_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       exit_code_q, exit_code_d;

  logic              idle_boot;
  logic [1:0]        run_if;

  assign idle_boot = (boot_q == 2'd0);
  // Fast mode loads Cheshire over JTAG; the fast path is only used for Snitch.
  assign run_if    = (preload_q == IfFast) ? IfJtag : preload_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    boot_d      = boot_q;
    preload_d   = preload_q;
    sn_valid_d  = sn_valid_q;
    chip_rst_d  = chip_rst_q;
    if_sel_d    = if_sel_q;
    init_req_d  = init_req_q;
    load_req_d  = load_req_q;
    run_req_d   = run_req_q;
    read_req_d  = read_req_q;
    poll_req_d  = poll_req_q;
    done_d      = done_q;
    error_d     = error_q;
    err_code_d  = err_code_q;
    exit_code_d = exit_code_q;

    case (state_q)
      StIdle: begin
        chip_rst_d = 1'b0;
        if (start_i) begin
          boot_d     = boot_mode_i;
          preload_d  = preload_mode_i;
          sn_valid_d = sn_valid_i;
          chip_rst_d = 1'b1;
          cnt_d      = '0;
          state_d    = StReset;
        end
      end
      StReset: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(RstCycles - 1)) begin
          chip_rst_d = 1'b0;
          state_d    = StDispatch;
        end
      end
      StDispatch: begin
        if (boot_q == 2'd1) begin
          error_d    = 1'b1;
          done_d     = 1'b1;
          err_code_d = ErrBoot;
          state_d    = StError;
        end else if (boot_q[1] || preload_q == IfJtag || preload_q == IfFast) begin
          if (!boot_q[1] && preload_q == IfUart && sn_valid_q) begin
            state_d = StError;
          end
          if_sel_d   = IfJtag;
          init_req_d = 1'b1;
          state_d    = StInit;
        end else if (preload_q == IfUart && sn_valid_q) begin
          error_d    = 1'b1;
          done_d     = 1'b1;
          err_code_d = ErrPreload;
          state_d    = StError;
        end else if (sn_valid_q) begin
          if_sel_d   = preload_q;
          load_req_d = 1'b1;
          state_d    = StLoad;
        end else begin
          if_sel_d  = run_if;
          run_req_d = 1'b1;
          state_d   = StRun;
        end
      end
      StInit: begin
        if (init_ack_i) begin
          init_req_d = 1'b0;
          if (!idle_boot) begin
            if_sel_d   = IfJtag;
            poll_req_d = 1'b1;
            state_d    = StPoll;
          end else if (sn_valid_q) begin
            if_sel_d   = preload_q;
            load_req_d = 1'b1;
            state_d    = StLoad;
          end else begin
            if_sel_d  = run_if;
            run_req_d = 1'b1;
            state_d   = StRun;
          end
        end
      end
      StLoad: begin
        if (load_ack_i) begin
          load_req_d = 1'b0;
          if_sel_d   = run_if;
          run_req_d  = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (run_ack_i) begin
          run_req_d  = 1'b0;
          poll_req_d = 1'b1;
          state_d    = StPoll;
        end
      end
      StPoll: begin
        if (poll_ack_i) begin
          poll_req_d = 1'b0;
          if (poll_data_i[0]) begin
            exit_code_d = {1'b0, poll_data_i[31:1]};
            if (idle_boot && preload_q == IfFast && sn_valid_q) begin
              if_sel_d   = IfFast;
              read_req_d = 1'b1;
              state_d    = StRead;
            end else begin
              state_d = StDrain;
            end
          end else begin
            cnt_d   = '0;
            state_d = StPollWait;
          end
        end
      end
      StPollWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(PollInterval - 1)) begin
          poll_req_d = 1'b1;
          state_d    = StPoll;
        end
      end
      StRead: begin
        if (read_ack_i) begin
          read_req_d = 1'b0;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (!uart_busy_i) begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone, StError: ;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      boot_q      <= '0;
      preload_q   <= '0;
      sn_valid_q  <= 1'b0;
      chip_rst_q  <= 1'b1;
      if_sel_q    <= '0;
      init_req_q  <= 1'b0;
      load_req_q  <= 1'b0;
      run_req_q   <= 1'b0;
      read_req_q  <= 1'b0;
      poll_req_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= '0;
      exit_code_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      boot_q      <= boot_d;
      preload_q   <= preload_d;
      sn_valid_q  <= sn_valid_d;
      chip_rst_q  <= chip_rst_d;
      if_sel_q    <= if_sel_d;
      init_req_q  <= init_req_d;
      load_req_q  <= load_req_d;
      run_req_q   <= run_req_d;
      read_req_q  <= read_req_d;
      poll_req_q  <= poll_req_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign boot_mode_o = boot_q;
  assign chip_rst_o  = chip_rst_q;
  assign if_sel_o    = if_sel_q;
  assign init_req_o  = init_req_q;
  assign load_req_o  = load_req_q;
  assign run_req_o   = run_req_q;
  assign read_req_o  = read_req_q;
  assign poll_req_o  = poll_req_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_code_o  = err_code_q;
  assign exit_code_o = exit_code_q;

endmodule

// File: tb/tb_fixture_picobello.sv
// Directed bench for fixture_picobello: a responder acks requests two cycles
// after they rise and logs request order, interface and EOC poll spacing.
module tb_fixture_picobello;

  localparam int RST = 4;
  localparam int PI  = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  boot_mode_i = '0;
  logic [1:0]  preload_mode_i = '0;
  logic        sn_valid_i = 1'b0;
  logic [1:0]  boot_mode_o;
  logic        chip_rst_o;
  logic [1:0]  if_sel_o;
  logic        init_req_o, load_req_o, run_req_o, read_req_o, poll_req_o;
  logic        init_ack_i = 1'b0, load_ack_i = 1'b0, run_ack_i = 1'b0;
  logic        read_ack_i = 1'b0, poll_ack_i = 1'b0;
  logic [31:0] poll_data_i = '0;
  logic        uart_busy_i = 1'b0;
  logic        done_o, error_o;
  logic [1:0]  err_code_o;
  logic [31:0] exit_code_o;

  fixture_picobello #(.RstCycles(RST), .PollInterval(PI)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .boot_mode_i(boot_mode_i), .preload_mode_i(preload_mode_i), .sn_valid_i(sn_valid_i),
    .boot_mode_o(boot_mode_o), .chip_rst_o(chip_rst_o), .if_sel_o(if_sel_o),
    .init_req_o(init_req_o), .init_ack_i(init_ack_i),
    .load_req_o(load_req_o), .load_ack_i(load_ack_i),
    .run_req_o(run_req_o), .run_ack_i(run_ack_i),
    .read_req_o(read_req_o), .read_ack_i(read_ack_i),
    .poll_req_o(poll_req_o), .poll_ack_i(poll_ack_i), .poll_data_i(poll_data_i),
    .uart_busy_i(uart_busy_i), .done_o(done_o), .error_o(error_o),
    .err_code_o(err_code_o), .exit_code_o(exit_code_o)
  );

  always #5 clk_i = ~clk_i;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responder state; log entries are kind*4 + if_sel (0 init,1 load,2 run,3 poll,4 read).
  logic [31:0] polls[$];
  int          req_log[$];
  int          gaps[$];
  int          cyc = 0, fall_cyc = 0, rst_hi_cnt = 0, sel_bad = 0;
  bit          have_fall = 0;
  logic [4:0]  ack_en = 5'b11111;

  initial begin : responder
    logic [4:0] reqs, prev, acks;
    logic [1:0] prev_sel;
    int age[5];
    prev = '0; acks = '0; prev_sel = '0;
    for (int k = 0; k < 5; k++) age[k] = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (chip_rst_o) rst_hi_cnt++;
      reqs = {read_req_o, poll_req_o, run_req_o, load_req_o, init_req_o};
      if ((reqs & prev) != 0 && if_sel_o != prev_sel) sel_bad++;
      for (int k = 0; k < 5; k++) begin
        if (reqs[k] && !prev[k]) begin
          req_log.push_back(k * 4 + int'(if_sel_o));
          if (k == 3 && have_fall) gaps.push_back(cyc - fall_cyc);
        end
        if (k == 3 && !reqs[k] && prev[k]) begin
          fall_cyc = cyc;
          have_fall = 1;
        end
        if (!reqs[k] || acks[k]) begin
          acks[k] = 1'b0;
          age[k] = 0;
        end else if (ack_en[k]) begin
          age[k]++;
          if (age[k] == 2) begin
            acks[k] = 1'b1;
            if (k == 3) poll_data_i = (polls.size() > 0) ? polls.pop_front() : 32'h0;
          end
        end
      end
      prev = reqs;
      prev_sel = if_sel_o;
      {read_ack_i, poll_ack_i, run_ack_i, load_ack_i, init_ack_i} = acks;
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic start_seq(input logic [1:0] boot, input logic [1:0] pre, input logic sn);
    do_reset();
    req_log.delete();
    gaps.delete();
    have_fall = 0;
    rst_hi_cnt = 0;
    sel_bad = 0;
    boot_mode_i = boot;
    preload_mode_i = pre;
    sn_valid_i = sn;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    // Config is latched; scramble inputs to show they are ignored afterwards.
    boot_mode_i = 2'd1;
    preload_mode_i = 2'd2;
    sn_valid_i = ~sn;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_o && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    check(tag, done_o, 1);
  endtask

  task automatic check_log(input int n, input int e0, input int e1, input int e2,
                           input int e3, input int e4);
    int e[5];
    e = '{e0, e1, e2, e3, e4};
    check("log_len", req_log.size(), n);
    for (int i = 0; i < n; i++) check("log_entry", (i < req_log.size()) ? req_log[i] : -1, e[i]);
    check("if_sel_stable", sel_bad, 0);
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) @(negedge clk_i);
    check("rst_chip_rst", chip_rst_o, 1);
    check("rst_done", done_o, 0);
    check("rst_error", error_o, 0);
    check("rst_reqs", {init_req_o, load_req_o, run_req_o, read_req_o, poll_req_o}, 0);
    check("rst_exit", exit_code_o, 0);
    check("rst_boot_mode", boot_mode_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_chip_rst_release", chip_rst_o, 0);

    // Idle boot, serial link, Snitch present, two failed polls
    polls = '{32'h0, 32'h0, 32'h1};
    start_seq(2'd0, 2'd1, 1'b1);
    wait_done("t1_done");
    check("t1_chip_rst_cycles", rst_hi_cnt, RST);
    check_log(5, 5, 9, 13, 13, 13);
    check("t1_gap_count", gaps.size(), 2);
    for (int i = 0; i < 2; i++) check("t1_poll_gap", (i < gaps.size()) ? gaps[i] : -1, PI);
    check("t1_exit", exit_code_o, 0);
    check("t1_error", error_o, 0);

    // Idle boot, fast mode, readback at the end
    polls = '{32'h0000_000B};
    start_seq(2'd0, 2'd3, 1'b1);
    wait_done("t2_done");
    check_log(5, 0, 7, 8, 12, 19);
    check("t2_exit", exit_code_o, 5);
    check("t2_boot_mode", boot_mode_o, 0);

    // Snitch preload over UART is unsupported
    start_seq(2'd0, 2'd2, 1'b1);
    wait_done("t3_done");
    check("t3_error", error_o, 1);
    check("t3_err_code", err_code_o, 2);
    check("t3_no_requests", req_log.size(), 0);
    check("t3_exit", exit_code_o, 0);

    // SD boot is unsupported
    start_seq(2'd1, 2'd0, 1'b0);
    wait_done("t4_done");
    check("t4_error", error_o, 1);
    check("t4_err_code", err_code_o, 1);
    check("t4_no_requests", req_log.size(), 0);

    // Autonomous boot: init then poll only
    polls = '{32'h8000_0001};
    start_seq(2'd2, 2'd0, 1'b1);
    wait_done("t5_done");
    check_log(2, 0, 12, 0, 0, 0);
    check("t5_exit", exit_code_o, 32'h4000_0000);
    check("t5_boot_mode", boot_mode_o, 2);
    check("t5_error", error_o, 0);

    // UART still draining after EOC
    polls = '{32'h0000_0007};
    uart_busy_i = 1'b1;
    start_seq(2'd0, 2'd2, 1'b0);
    n = 0;
    while (!(polls.size() == 0 && !poll_req_o) && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("t6_eoc_seen", polls.size() == 0 && !poll_req_o, 1);
    n = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
    check("t6_done_while_busy", n, 0);
    uart_busy_i = 1'b0;
    wait_done("t6_done");
    check("t6_exit", exit_code_o, 3);
    check_log(2, 10, 14, 0, 0, 0);

    // Reset while a run request is pending, then a clean rerun
    ack_en = 5'b11011;
    start_seq(2'd0, 2'd1, 1'b0);
    n = 0;
    while (!run_req_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    check("t7_run_pending", run_req_o, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("t7_run_dropped", run_req_o, 0);
    check("t7_chip_rst", chip_rst_o, 1);
    check("t7_done", done_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("t7_idle_chip_rst", chip_rst_o, 0);
    ack_en = 5'b11111;
    polls = '{32'h0000_0015};
    start_seq(2'd0, 2'd1, 1'b0);
    wait_done("t7_rerun_done");
    check("t7_rerun_exit", exit_code_o, 32'h0A);
    check_log(2, 9, 13, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fixture_picobello.md
Name: fixture_picobello

Overview:
- Synthesizable boot/test sequencer for the Picobello top-level harness.
- Latches the boot and preload configuration, then drives chip reset.
- For idle boot it dispatches Snitch/Cheshire binary preload and run over the selected debug interface (JTAG, serial link, UART, fast mode); for autonomous boot it only polls.
- Polls the end-of-computation (EOC) word, then waits for UART drain and flags completion with the exit code.

Parameters:
RstCycles, 16, cycles chip_rst_o stays asserted (>=1)
PollInterval, 64, idle cycles between EOC polls (>=1)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; sampled only in IDLE
boot_mode_i  in  2  0 idle, 1 SD (unsupported), 2/3 autonomous
preload_mode_i  in  2  0 JTAG, 1 serial link, 2 UART, 3 fast
sn_valid_i  in  1  Snitch binary present
boot_mode_o  in→out  2  latched boot mode to chip pins
chip_rst_o  out  1  chip reset, active-high
if_sel_o  out  2  interface for current request (0 JTAG, 1 slink, 2 UART, 3 fast)
init_req_o / init_ack_i  out/in  1/1  interface init (JTAG only)
load_req_o / load_ack_i  out/in  1/1  Snitch ELF preload
run_req_o / run_ack_i  out/in  1/1  Cheshire ELF load+run
read_req_o / read_ack_i  out/in  1/1  fast-mode result readback
poll_req_o / poll_ack_i  out/in  1/1  EOC word read
poll_data_i  in  32  EOC word, valid with poll_ack_i
uart_busy_i  in  1  UART receiving a byte
done_o  out  1  sequence finished (sticky)
error_o  out  1  unsupported configuration (sticky)
err_code_o  out  2  0 none, 1 unsupported boot mode, 2 unsupported Snitch preload, 3 reserved
exit_code_o  out  32  EOC value >> 1

Behaviour:
- Reset: FSM to IDLE; all outputs 0, except chip_rst_o = 1.
  - In IDLE, chip_rst_o deasserts one cycle after reset release.
- IDLE: start_i high → latch boot_mode_i, preload_mode_i, sn_valid_i; drive boot_mode_o; go to RESET. Config inputs are ignored after latching.
- RESET: chip_rst_o = 1 for exactly RstCycles cycles, then 0. Go to DISPATCH.
- DISPATCH (1 cycle) transitions:
  - boot 1 → ERROR, code 1.
  - boot 2/3 → INIT with if_sel = 0, then POLL.
  - boot 0, preload 2 with sn_valid → ERROR, code 2.
  - boot 0, preload 0/3 → INIT.
  - boot 0, preload 1/2 → skip INIT; go to LOAD if sn_valid, else RUN.
- Requests: each *_req_o is a level held from state entry until its ack is sampled high.
  - The state advances the cycle after the ack.
  - Acks in other states are ignored.
  - if_sel_o is stable while a request is held.
- INIT → LOAD if sn_valid, else RUN.
- LOAD: if_sel = latched preload mode (3 → fast). → RUN.
- RUN: if_sel = preload mode, except 3 maps to 0 (Cheshire over JTAG). → POLL.
- POLL:
  - In idle boot, if_sel = RUN's interface; in autonomous boot, 0.
  - On ack with poll_data_i[0] = 1: exit_code_o <= poll_data_i >> 1 (zero-filled MSB), then → READ if preload 3 and sn_valid, else → DRAIN.
  - On ack with bit0 = 0: wait PollInterval cycles in POLL_WAIT, then re-request.
- READ: if_sel = 3. → DRAIN.
- DRAIN: wait until uart_busy_i == 0 (zero extra cycles if already 0). → DONE.
- DONE: done_o = 1, held until rst_i.
- ERROR: error_o = 1, done_o = 1, err_code_o set; exit_code_o stays 0; held until rst_i.
- rst_i mid-sequence aborts immediately: all requests drop in the reset cycle, state returns to IDLE.
- start_i outside IDLE has no effect.

Test Plan:
- RstCycles=4, boot 0, preload 1, sn_valid=1; acks after 2 cycles; poll returns 0 twice then 0x0000_0001:
  - chip_rst_o high exactly 4 cycles.
  - LOAD then RUN with if_sel=1.
  - Poll gaps of PollInterval cycles.
  - exit_code_o=0, done_o=1.
- Boot 0, preload 3, sn_valid=1; poll returns 0x0000_000B:
  - Request order init(0), load(3), run(0), poll(0), read(3).
  - exit_code_o=5.
- Boot 0, preload 2, sn_valid=1 → error_o=1, err_code_o=2, done_o=1; no load/run request ever asserted.
- Boot 1 → err_code_o=1. Boot 2 → only init then poll; poll 0x8000_0001 → exit_code_o=0x4000_0000.
- uart_busy_i held high 10 cycles after EOC → done_o rises only after busy falls.
- rst_i asserted while run_req_o pending → run_req_o=0 next cycle; FSM in IDLE with chip_rst_o=1; new start re-runs cleanly.
